// File: rtl/button_debounce.sv
// Debounce front end for one mechanical key: two-flop synchroniser, stability
// counter and a four-state FSM producing a registered, active-high press level.
module button_debounce #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_WIDTH     = 16,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_raw,
    output logic       level,
    output logic [1:0] state
);

    localparam logic [1:0] RELEASED     = 2'b00;
    localparam logic [1:0] PRESS_WAIT   = 2'b01;
    localparam logic [1:0] PRESSED      = 2'b10;
    localparam logic [1:0] RELEASE_WAIT = 2'b11;

    localparam logic                 RAW_IDLE = ACTIVE_LOW;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 pressed_n;
    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 level_q;
    logic                 level_d;

    // Two-flop synchroniser; resets to the unpressed pad value so a reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RAW_IDLE;
            sync2_q <= RAW_IDLE;
        end else begin
            sync1_q <= button_raw;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_n = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Next-state and counter logic; a reverting input during a wait falls back to the old stable state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (pressed_n) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = RELEASED;
                end
            end
            PRESS_WAIT: begin
                if (!pressed_n) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!pressed_n) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = PRESSED;
                end
            end
            RELEASE_WAIT: begin
                if (pressed_n) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);

    // State, counter and level registers; level is taken from the next state so it lands with the state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
    assign state = state_q;

endmodule

// File: tb/tb_button_debounce.sv
// Table-driven bench for button_debounce with STABLE_CYCLES=4: one active-low
// instance and one active-high instance, expected values queued per vector.
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_a;
    logic       raw_b;
    logic       level_a;
    logic       level_b;
    logic [1:0] state_a;
    logic [1:0] state_b;

    always #5 clk = ~clk;

    button_debounce #(
        .STABLE_CYCLES(4),
        .CNT_WIDTH    (3),
        .ACTIVE_LOW   (1'b1)
    ) dut_a (
        .clk       (clk),
        .reset     (reset),
        .button_raw(raw_a),
        .level     (level_a),
        .state     (state_a)
    );

    button_debounce #(
        .STABLE_CYCLES(4),
        .CNT_WIDTH    (3),
        .ACTIVE_LOW   (1'b0)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .button_raw(raw_b),
        .level     (level_b),
        .state     (state_b)
    );

    typedef struct {
        logic       sel;
        logic       raw;
        logic       l;
        logic [1:0] s;
    } vec_t;

    typedef struct {
        logic       sel;
        logic       l;
        logic [1:0] s;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   applied     = 0;
    int   miscompares = 0;
    int   split_idx   = 0;

    function automatic void add(input logic sel, input logic raw, input logic l, input logic [1:0] s);
        vec_t v;
        v.sel = sel;
        v.raw = raw;
        v.l   = l;
        v.s   = s;
        vecs.push_back(v);
    endfunction

    function automatic void expect_out(input logic sel, input logic l, input logic [1:0] s, input int tag);
        exp_t e;
        e.sel = sel;
        e.l   = l;
        e.s   = s;
        e.tag = tag;
        sb.push_back(e);
    endfunction

    task automatic check_out();
        exp_t       e;
        logic       al;
        logic [1:0] as_v;
        applied++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: no expected entry queued");
        end else begin
            e    = sb.pop_front();
            al   = e.sel ? level_b : level_a;
            as_v = e.sel ? state_b : state_a;
            if (al !== e.l || as_v !== e.s) begin
                miscompares++;
                $display("FAIL vec%0d dut%0d: got level=%b state=%b, expected level=%b state=%b",
                         e.tag, e.sel, al, as_v, e.l, e.s);
            end
        end
    endtask

    task automatic apply(input int i);
        @(negedge clk);
        if (vecs[i].sel) raw_b = vecs[i].raw;
        else             raw_a = vecs[i].raw;
        expect_out(vecs[i].sel, vecs[i].l, vecs[i].s, i);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Release sequence from PRESSED with the key held released from the first edge.
    function automatic void add_release(input logic sel, input logic rel);
        add(sel, rel, 1'b1, 2'b10);
        add(sel, rel, 1'b1, 2'b10);
        for (int k = 0; k < 4; k++) add(sel, rel, 1'b1, 2'b11);
        add(sel, rel, 1'b0, 2'b00);
    endfunction

    // Press sequence from RELEASED with the key held pressed from the first edge.
    function automatic void add_press(input logic sel, input logic prs);
        add(sel, prs, 1'b0, 2'b00);
        add(sel, prs, 1'b0, 2'b00);
        for (int k = 0; k < 4; k++) add(sel, prs, 1'b0, 2'b01);
        add(sel, prs, 1'b1, 2'b10);
    endfunction

    initial begin
        // Idle after reset: 20 cycles with the key released.
        for (int k = 0; k < 20; k++) add(1'b0, 1'b1, 1'b0, 2'b00);
        // Clean press, then held.
        add_press(1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 2'b10);
        add(1'b0, 1'b0, 1'b1, 2'b10);
        // Two-cycle release glitch while held: visits 11, returns to 10.
        add(1'b0, 1'b1, 1'b1, 2'b10);
        add(1'b0, 1'b1, 1'b1, 2'b10);
        add(1'b0, 1'b0, 1'b1, 2'b11);
        add(1'b0, 1'b0, 1'b1, 2'b11);
        add(1'b0, 1'b0, 1'b1, 2'b10);
        add(1'b0, 1'b0, 1'b1, 2'b10);
        // Held release.
        add_release(1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 2'b00);
        add(1'b0, 1'b1, 1'b0, 2'b00);
        // Bounce: low 3, high 1, low 2, high 1, then low from Ef.
        add(1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b0, 1'b1, 1'b0, 2'b01);
        add(1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b1, 1'b0, 2'b01);
        add(1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b0, 1'b0, 1'b1, 2'b10);
        add(1'b0, 1'b0, 1'b1, 2'b10);
        add_release(1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 2'b00);
        // Press into PRESS_WAIT, then a reset pulse is applied by hand.
        add(1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 2'b01);
        add(1'b0, 1'b0, 1'b0, 2'b01);
        split_idx = vecs.size();
        // After reset deassert the held key is debounced from scratch.
        add_press(1'b0, 1'b0);
        // Active-high key on the second instance.
        add_press(1'b1, 1'b1);
        add(1'b1, 1'b1, 1'b1, 2'b10);
        add_release(1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 2'b00);

        reset = 1'b1;
        raw_a = 1'b1;
        raw_b = 1'b0;
        #2;
        expect_out(1'b0, 1'b0, 2'b00, -1);
        check_out();
        expect_out(1'b1, 1'b0, 2'b00, -2);
        check_out();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < split_idx; i++) apply(i);

        // Asynchronous reset pulse between edges while dut_a is in PRESS_WAIT.
        #1;
        reset = 1'b1;
        #1;
        expect_out(1'b0, 1'b0, 2'b00, -3);
        check_out();
        expect_out(1'b1, 1'b0, 2'b00, -4);
        check_out();
        #1;
        reset = 1'b0;

        for (int i = split_idx; i < vecs.size(); i++) apply(i);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
